// File: rtl/idex_alu_decode_pkg.sv
// Shared control definitions for the ID/EX ALU decode stage:
// ALUOp codes, opcode/funct constants and the ID/EX bundle.
package idex_alu_decode_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SRL  = 5'd3,
    ALU_SRA  = 5'd4,
    ALU_AND  = 5'd5,
    ALU_OR   = 5'd6,
    ALU_XOR  = 5'd7,
    ALU_NOR  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_SLTU = 5'd10,
    ALU_LUI  = 5'd11,
    ALU_BNE  = 5'd12,
    ALU_BLEZ = 5'd13,
    ALU_BGTZ = 5'd14,
    ALU_BLTZ = 5'd15,
    ALU_BGEZ = 5'd16
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIM = 6'h01;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic        valid;
    aluop_e      aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        take_if_zero;
  } id_ex_t;

  localparam id_ex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/idex_alu_decode_alu_op_dec.sv
// Combinational decode of one instruction word into the
// next ID/EX bundle plus an illegal-instruction flag.
module alu_op_dec
  import idex_alu_decode_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output id_ex_t      o_nxt,
  output logic        o_illegal
);

  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic        w_unused;
  id_ex_t      w_d;
  logic        w_ill;

  assign w_op     = i_instr[31:26];
  assign w_rt     = i_instr[20:16];
  assign w_rd     = i_instr[15:11];
  assign w_shamt  = i_instr[10:6];
  assign w_funct  = i_instr[5:0];
  assign w_sext   = {{16{i_instr[15]}}, i_instr[15:0]};
  assign w_zext   = {16'b0, i_instr[15:0]};
  assign w_unused = ^i_instr[25:21];

  always_comb begin
    w_d       = IDEX_BUBBLE;
    w_ill     = 1'b0;
    w_d.valid = 1'b1;
    w_d.a     = i_rs_data;
    case (w_op)
      OP_RTYPE: begin
        w_d.b         = i_rt_data;
        w_d.dest      = w_rd;
        w_d.reg_write = 1'b1;
        case (w_funct)
          F_ADD, F_ADDU: w_d.aluop = ALU_ADD;
          F_SUB, F_SUBU: w_d.aluop = ALU_SUB;
          F_AND:  w_d.aluop = ALU_AND;
          F_OR:   w_d.aluop = ALU_OR;
          F_XOR:  w_d.aluop = ALU_XOR;
          F_NOR:  w_d.aluop = ALU_NOR;
          F_SLT:  w_d.aluop = ALU_SLT;
          F_SLTU: w_d.aluop = ALU_SLTU;
          F_SLL: begin
            w_d.aluop = ALU_SLL;
            w_d.a     = {27'b0, w_shamt};
          end
          F_SRL: begin
            w_d.aluop = ALU_SRL;
            w_d.a     = {27'b0, w_shamt};
          end
          F_SRA: begin
            w_d.aluop = ALU_SRA;
            w_d.a     = {27'b0, w_shamt};
          end
          F_SLLV: w_d.aluop = ALU_SLL;
          F_SRLV: w_d.aluop = ALU_SRL;
          F_SRAV: w_d.aluop = ALU_SRA;
          default: w_ill = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW: begin
        w_d.b         = w_sext;
        w_d.dest      = w_rt;
        w_d.reg_write = (w_op != OP_SW);
        w_d.mem_rd    = (w_op == OP_LW);
        w_d.mem_wr    = (w_op == OP_SW);
        unique case (1'b1)
          (w_op == OP_SLTI):  w_d.aluop = ALU_SLT;
          (w_op == OP_SLTIU): w_d.aluop = ALU_SLTU;
          default:            w_d.aluop = ALU_ADD;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_d.b         = w_zext;
        w_d.dest      = w_rt;
        w_d.reg_write = 1'b1;
        unique case (1'b1)
          (w_op == OP_ANDI): w_d.aluop = ALU_AND;
          (w_op == OP_ORI):  w_d.aluop = ALU_OR;
          (w_op == OP_XORI): w_d.aluop = ALU_XOR;
          default:           w_d.aluop = ALU_LUI;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        w_d.aluop        = ALU_BNE;
        w_d.b            = i_rt_data;
        w_d.branch       = 1'b1;
        w_d.take_if_zero = (w_op == OP_BNE);
      end
      OP_BLEZ, OP_BGTZ: begin
        w_d.aluop        = (w_op == OP_BLEZ) ? ALU_BLEZ
                                             : ALU_BGTZ;
        w_d.branch       = 1'b1;
        w_d.take_if_zero = 1'b1;
      end
      OP_REGIM: begin
        w_d.branch       = 1'b1;
        w_d.take_if_zero = 1'b1;
        unique case (1'b1)
          (w_rt == 5'd0): w_d.aluop = ALU_BLTZ;
          (w_rt == 5'd1): w_d.aluop = ALU_BGEZ;
          default:        w_ill     = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // $0 is hardwired; never claim a write to it
    if (w_d.dest == 5'd0) w_d.reg_write = 1'b0;
    o_illegal = w_ill;
    o_nxt     = w_ill ? IDEX_BUBBLE : w_d;
  end

endmodule

// File: rtl/idex_alu_decode.sv
// ID/EX pipeline register with stall/flush priority around
// the combinational ALU-op decoder.
module idex_alu_decode
  import idex_alu_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  output logic        ex_valid,
  output logic [4:0]  ex_aluop,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_branch,
  output logic        ex_take_if_zero,
  output logic        ex_illegal
);

  id_ex_t w_nxt;
  logic   w_ill;
  id_ex_t r_q;
  logic   r_ill;

  alu_op_dec u_dec (
    .i_instr   (id_instr),
    .i_rs_data (id_rs_data),
    .i_rt_data (id_rt_data),
    .o_nxt     (w_nxt),
    .o_illegal (w_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= IDEX_BUBBLE;
      r_ill <= 1'b0;
    end else if (flush) begin
      r_q   <= IDEX_BUBBLE;
      r_ill <= 1'b0;
    end else if (stall) begin
      r_q   <= r_q;
      r_ill <= r_ill;
    end else if (!id_valid) begin
      r_q   <= IDEX_BUBBLE;
      r_ill <= 1'b0;
    end else begin
      r_q   <= w_nxt;
      r_ill <= w_ill;
    end
  end

  assign ex_valid        = r_q.valid;
  assign ex_aluop        = r_q.aluop;
  assign ex_a            = r_q.a;
  assign ex_b            = r_q.b;
  assign ex_dest         = r_q.dest;
  assign ex_reg_write    = r_q.reg_write;
  assign ex_mem_rd       = r_q.mem_rd;
  assign ex_mem_wr       = r_q.mem_wr;
  assign ex_branch       = r_q.branch;
  assign ex_take_if_zero = r_q.take_if_zero;
  assign ex_illegal      = r_ill;

endmodule

// File: tb/tb_idex_alu_decode.sv
// Directed-vector bench for idex_alu_decode with
// hand-computed expectations.
module tb_idex_alu_decode;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        ex_valid;
  logic [4:0]  ex_aluop;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_rd, ex_mem_wr;
  logic        ex_branch, ex_take_if_zero, ex_illegal;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  idex_alu_decode dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .ex_valid        (ex_valid),
    .ex_aluop        (ex_aluop),
    .ex_a            (ex_a),
    .ex_b            (ex_b),
    .ex_dest         (ex_dest),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_wr       (ex_mem_wr),
    .ex_branch       (ex_branch),
    .ex_take_if_zero (ex_take_if_zero),
    .ex_illegal      (ex_illegal)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins,
                       input logic [31:0] rs,
                       input logic [31:0] rt);
    id_valid   = 1'b1;
    id_instr   = ins;
    id_rs_data = rs;
    id_rt_data = rt;
    step();
  endtask

  logic [31:0] alu_res;
  logic [31:0] h_a, h_b;
  logic [4:0]  h_op;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_instr = 32'h2128FFFF;
    id_rs_data = 32'd5; id_rt_data = 32'd9;
    step();
    chk("rst_valid", {31'b0, ex_valid}, 0);
    chk("rst_aluop", {27'b0, ex_aluop}, 0);
    chk("rst_a", ex_a, 0);
    chk("rst_ctl", {26'b0, ex_reg_write, ex_mem_rd,
        ex_mem_wr, ex_branch, ex_take_if_zero,
        ex_illegal}, 0);
    step();
    rst = 1'b0;

    // ADDI $t0,$t1,-1
    issue(32'h2128FFFF, 32'd5, 32'h1234);
    chk("addi_aluop", {27'b0, ex_aluop}, 0);
    chk("addi_a", ex_a, 5);
    chk("addi_b", ex_b, 32'hFFFFFFFF);
    chk("addi_dest", {27'b0, ex_dest}, 8);
    chk("addi_wr_v", {30'b0, ex_reg_write, ex_valid}, 3);

    // SRA $t0,$t1,4
    issue(32'h00094103, 32'd5, 32'h80000000);
    chk("sra_aluop", {27'b0, ex_aluop}, 4);
    chk("sra_a", ex_a, 4);
    chk("sra_b", ex_b, 32'h80000000);
    alu_res = 32'($signed(ex_b) >>> ex_a[4:0]);
    chk("sra_alu", alu_res, 32'hF8000000);

    // BEQ
    issue(32'h11090003, 32'd7, 32'd7);
    chk("beq_aluop", {27'b0, ex_aluop}, 12);
    chk("beq_br_tiz_wr", {29'b0, ex_branch,
        ex_take_if_zero, ex_reg_write}, 3'b100);
    chk("beq_b", ex_b, 7);

    // BGEZ
    issue(32'h05210003, 32'd7, 32'd7);
    chk("bgez_aluop", {27'b0, ex_aluop}, 16);
    chk("bgez_br_tiz", {30'b0, ex_branch,
        ex_take_if_zero}, 2'b11);
    chk("bgez_b", ex_b, 0);

    // BLEZ
    issue(32'h19000002, 32'd3, 32'd7);
    chk("blez_aluop", {27'b0, ex_aluop}, 13);

    // SW $t0,-4($t1)
    issue(32'hAD28FFFC, 32'h100, 32'd1);
    chk("sw_ctl", {29'b0, ex_mem_wr, ex_mem_rd,
        ex_reg_write}, 3'b100);
    chk("sw_b", ex_b, 32'hFFFFFFFC);

    // ORI then stall with changing inputs
    issue(32'h35288001, 32'h0F0F0000, 32'd1);
    chk("ori_aluop", {27'b0, ex_aluop}, 6);
    chk("ori_b", ex_b, 32'h00008001);
    h_a = ex_a; h_b = ex_b; h_op = ex_aluop;
    chk("ori_a", h_a, 32'h0F0F0000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(32'hFC000000 + i, 32'hDEAD0000 + i,
            32'd99);
      chk("stall_a", ex_a, 32'h0F0F0000);
      chk("stall_b", ex_b, 32'h00008001);
      chk("stall_op", {27'b0, ex_aluop}, 6);
      chk("stall_ill", {31'b0, ex_illegal}, 0);
    end
    flush = 1'b1;
    issue(32'h2128FFFF, 32'd5, 32'd0);
    chk("flush_v", {31'b0, ex_valid}, 0);
    chk("flush_a", ex_a, 0);
    chk("flush_wr", {31'b0, ex_reg_write}, 0);
    stall = 1'b0; flush = 1'b0;

    // Illegal opcode: one-cycle flag
    issue(32'hFC000000, 32'd1, 32'd2);
    chk("ill_v", {31'b0, ex_valid}, 0);
    chk("ill_flag", {31'b0, ex_illegal}, 1);
    chk("ill_a", ex_a, 0);
    id_valid = 1'b0;
    step();
    chk("ill_clear", {31'b0, ex_illegal}, 0);

    // Illegal REGIMM rt=2, held by stall, cleared by flush
    issue(32'h04420003, 32'd1, 32'd2);
    chk("ill2_flag", {31'b0, ex_illegal}, 1);
    stall = 1'b1;
    step();
    chk("ill2_hold", {31'b0, ex_illegal}, 1);
    flush = 1'b1;
    step();
    chk("ill2_flush", {31'b0, ex_illegal}, 0);
    stall = 1'b0; flush = 1'b0;

    // ADDU $0,$t1,$t2
    issue(32'h012A0021, 32'd1, 32'd2);
    chk("addu0_v", {31'b0, ex_valid}, 1);
    chk("addu0_wr", {31'b0, ex_reg_write}, 0);

    // All-zero word: valid no-op
    issue(32'h00000000, 32'd1, 32'd2);
    chk("nop_v_wr_ill", {29'b0, ex_valid,
        ex_reg_write, ex_illegal}, 3'b100);
    chk("nop_aluop", {27'b0, ex_aluop}, 2);

    // LW then id_valid=0 bubble
    issue(32'h8D28000C, 32'd1, 32'd2);
    chk("lw_rd_wr", {30'b0, ex_mem_rd,
        ex_reg_write}, 2'b11);
    id_valid = 1'b0;
    step();
    chk("idle_v", {31'b0, ex_valid}, 0);

    // Reset during stall
    issue(32'h2128FFFF, 32'd5, 32'd0);
    stall = 1'b1; rst = 1'b1;
    step();
    chk("rst_stall_v", {31'b0, ex_valid}, 0);
    chk("rst_stall_b", ex_b, 0);
    rst = 1'b0; stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idex_alu_decode.md
# idex_alu_decode

ID/EX boundary stage that produces the ALU's operation code and operands. It decodes the instruction word into a 5-bit ALUOp, selects and extends the A/B operands, and derives the destination and branch-sense control. It registers all of this into the ID/EX pipeline register under stall/flush control. Its outputs drive the combinational ALU and the EX-stage branch/write-back logic directly.

## Interface
Parameters:
- none; ALUOp encodings come from the shared control-definition include.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold the current ID/EX contents
- flush  in  1  replace the next ID/EX contents with a bubble
- id_valid  in  1  the ID-stage instruction is real
- id_instr  in  32  instruction word
- id_rs_data  in  32  register-file value of rs (already forwarded)
- id_rt_data  in  32  register-file value of rt (already forwarded)
- ex_valid  out  1  EX-stage instruction is real
- ex_aluop  out  5  ALUOp
- ex_a  out  32  ALU operand A
- ex_b  out  32  ALU operand B
- ex_dest  out  5  write-back register number
- ex_reg_write  out  1  write ALU result to ex_dest
- ex_mem_rd  out  1  load
- ex_mem_wr  out  1  store
- ex_branch  out  1  conditional branch
- ex_take_if_zero  out  1  branch taken when the ALU result is 0 (else taken when the result is 1)
- ex_illegal  out  1  one-cycle flag for an undecodable instruction

## Operation
Decode applies when id_valid=1.
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- Extensions:
  - sext = {16{imm[15]}, imm}
  - zext = {16'b0, imm}

R-type (op 0x00): A=rs_data, B=rt_data, dest=rd, reg_write=1.
- funct 0x20/0x21 ADD; 0x22/0x23 SUB
- funct 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
- funct 0x2A SLT, 0x2B SLTU
- funct 0x00/0x02/0x03 SLL/SRL/SRA with A={27'b0, shamt}
- funct 0x04/0x06/0x07 SLL/SRL/SRA with A=rs_data (the ALU shifts B by A[4:0])

I-type: A=rs_data, dest=rt, reg_write=1.
- 0x08/0x09 ADD with B=sext
- 0x0A SLT with B=sext; 0x0B SLTU with B=sext
- 0x0C AND, 0x0D OR, 0x0E XOR, each with B=zext
- 0x0F LUI with B=zext
- 0x23 load: ADD with B=sext, mem_rd=1
- 0x2B store: ADD with B=sext, mem_wr=1, reg_write=0

Branches: reg_write=0, branch=1, A=rs_data.
- 0x04 BEQ: op BNE, B=rt_data, take_if_zero=0
- 0x05 BNE: op BNE, B=rt_data, take_if_zero=1
- 0x06 BLEZ: op BLEZ, take_if_zero=1
- 0x07 BGTZ: op BGTZ, take_if_zero=1
- 0x01 with rt=0: op BLTZ, take_if_zero=1
- 0x01 with rt=1: op BGEZ, take_if_zero=1
- B=0 for the single-operand branches.

Write-enable rules:
- If dest=0, reg_write is forced to 0.
- An instruction word of all zeros (SLL $0) decodes as a valid no-op with reg_write=0.

Any other op/funct/rt combination is illegal: the stage loads a bubble and sets ex_illegal=1.

Bubble contents: valid=0, aluop=ADD (0), a=b=0, dest=0, and every control bit 0.

## Timing
- Reset value of every output is 0; ex_aluop=0 is ALUOP_ADD.
- Latency: one cycle from the ID inputs to the ex_* outputs.

Per rising edge, first matching rule wins:
1. rst: the register is cleared to a bubble.
2. flush: bubble is loaded; ex_illegal=0. Flush overrides stall.
3. stall: all ex_* outputs hold, including ex_illegal.
4. id_valid=0: bubble is loaded.
5. Otherwise the decoded values are loaded.

Notes:
- ex_illegal is high for exactly one cycle unless it is held by stall.
- Register data is captured at the edge that loads the instruction; later changes to id_rs_data do not affect held contents.
- Reset asserted mid-stall clears the register at that edge.

## Structure
- ALUOp encodings live in the shared control-definition include: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, AND=5, OR=6, XOR=7, NOR=8, SLT=9, SLTU=10, LUI=11, BNE=12, BLEZ=13, BGTZ=14, BLTZ=15, BGEZ=16.
- Opcode and funct constants go in the same include.
- Sub-module `alu_op_dec`: purely combinational decode (instruction plus operands in, next-state bundle plus illegal out).
- The top level holds only the pipeline register and the stall/flush priority logic.

## Test plan
- Reset: assert rst for 2 cycles, then release. All outputs are 0 on the first edge after assertion.
- ADDI $t0,$t1,-1 (0x2128FFFF) with rs_data=5, id_valid=1. Next cycle: aluop=0, a=5, b=0xFFFFFFFF, dest=8, reg_write=1.
- SRA $t0,$t1,4 (0x00094103) with rt_data=0x80000000. Next cycle: aluop=4, a=4, b=0x80000000; the ALU output is 0xF8000000.
- BEQ (0x11090003) gives aluop=12, branch=1, take_if_zero=0. BGEZ (0x05210003) gives aluop=16, take_if_zero=1.
- Load ORI, then hold stall for 3 cycles while changing id_instr: outputs are unchanged. Assert stall and flush together: the next cycle is a bubble.
- Instruction 0xFC000000 leads to ex_valid=0 and a one-cycle ex_illegal=1. ADDU targeting $0 leads to reg_write=0.
